// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, pixel/beat types and scan states for the frame-buffer scanout reader.
// Ports: none (package).
package fb_pkg;
  localparam int ADDRESS_WIDTH = 20;
  localparam int DATA_WIDTH = 15;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int FRAME_PIXELS = H_RES * V_RES;
  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef struct packed {
    pixel_t data;
    logic sof;
    logic eol;
  } fb_beat_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} scan_state_t;
  // Counter width for a dimension, never narrower than one bit.
  function automatic int dim_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fb_scanout_reader_fifo.sv
// fb_skid_fifo: 2-entry beat FIFO; entry 0 is always the head so the output is stable until popped.
// Ports: clk, rst (sync, active-high), push/din (write), pop (consume head), head (current entry), count (0..2).
module fb_skid_fifo #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  import fb_pkg::*;
  logic [W-1:0] m1;
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      m1 <= '0;
      count <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && count == 2'd2) head <= m1;
      else if (push && (count == 2'd0 || (pop && count == 2'd1))) head <= din;
      if (push && (count == 2'd2 ? pop : (count == 2'd1 && !pop))) m1 <= din;
    end
  end
  overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && count == 2'd2 && !pop));
endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: walks the frame buffer row-major and streams pixels with sof/eol sideband.
// Ports: clk, rst (sync, active-high), start (pulse from IDLE), busy;
//        READ_EN/rd_addr/rd_data (RAM read port, data valid one cycle after READ_EN);
//        pix_data/pix_valid/pix_ready/pix_sof/pix_eol (output stream), frame_done (pulse after last handshake).
// Option: define FB_SCANOUT_CONTINUOUS_EN to scan frames back-to-back until rst.
module fb_scanout_reader #(
  parameter int ADDRESS_WIDTH = fb_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH = fb_pkg::DATA_WIDTH,
  parameter int H_RES = fb_pkg::H_RES,
  parameter int V_RES = fb_pkg::V_RES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     READ_EN,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_sof,
  output logic                     pix_eol,
  output logic                     frame_done
);
  import fb_pkg::*;
  localparam int XW = dim_bits(H_RES);
  localparam int YW = dim_bits(V_RES);
  localparam int W = DATA_WIDTH + 3;
`ifdef FB_SCANOUT_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif
  scan_state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic inflight, tag_sof, tag_eol, tag_last, pop, is_eol, is_last, head_last;
  logic [1:0] cnt;
  logic [W-1:0] head;
  assign pix_valid = cnt != 2'd0;
  assign pop = pix_valid & pix_ready;
  assign is_eol = x == XW'(H_RES - 1);
  assign is_last = is_eol && y == YW'(V_RES - 1);
  // Issue only while the FIFO plus the read in flight, minus this cycle's pop, leaves a free slot.
  assign READ_EN = state == RUN && ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign busy = state != IDLE;
  // The extra last-of-frame tag rides with each beat so frame_done needs no output-side counters.
  assign {pix_data, pix_sof, pix_eol, head_last} = head;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      rd_addr <= '0;
      inflight <= 1'b0;
      tag_sof <= 1'b0;
      tag_eol <= 1'b0;
      tag_last <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      inflight <= READ_EN;
      frame_done <= pop & head_last;
      if (READ_EN) begin
        tag_sof <= x == '0 && y == '0;
        tag_eol <= is_eol;
        tag_last <= is_last;
        x <= is_eol ? '0 : x + 1'b1;
        y <= is_last ? '0 : is_eol ? y + 1'b1 : y;
        rd_addr <= is_last ? '0 : rd_addr + 1'b1;
      end
      if (state == IDLE && start) state <= RUN;
      else if (state == RUN && READ_EN && is_last && !CONTINUOUS) state <= DRAIN;
      else if (state == DRAIN && cnt == 2'd0 && !inflight) state <= IDLE;
    end
  end
  fb_skid_fifo #(.W(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .pop(pop),
    .din({rd_data, tag_sof, tag_eol, tag_last}),
    .head(head),
    .count(cnt)
  );
endmodule
